// File: rtl/tone_synth_if.sv
// Note-word / audio-output bundle between a song sequencer channel and its tone_synth.
// The sequencer side drives note_period; tone_synth drives the audio outputs.
interface tone_synth_if;
    logic        [15:0] note_period;
    logic               wave_out;
    logic signed [15:0] sample;
    logic               active;
    logic               note_change;

    modport master (
        output note_period,
        input  wave_out,
        input  sample,
        input  active,
        input  note_change
    );

    modport slave (
        input  note_period,
        output wave_out,
        output sample,
        output active,
        output note_change
    );
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone generator with an articulation gap on every note change.
// Optional decaying envelope enabled by defining TONE_ENVELOPE_EN.
module tone_synth #(
    parameter int unsigned        PRESCALE    = 4,
    parameter int unsigned        GAP_TICKS   = 2,
    parameter logic signed [15:0] AMP         = 16'sd8000,
    parameter int unsigned        DECAY_TICKS = 4096
) (
    input  logic         clk50,
    input  logic         reset,
    tone_synth_if.slave  bus
);

    typedef enum logic [1:0] {StSilent, StGap, StPlay} state_e;

    localparam logic [15:0] PreMax  = 16'(PRESCALE - 1);
    localparam logic [15:0] GapInit = 16'(GAP_TICKS);

    if (PRESCALE < 1 || PRESCALE > 65535 || GAP_TICKS > 65535 ||
        DECAY_TICKS < 1 || DECAY_TICKS > 65535) begin : g_bad_params
        $error("tone_synth: parameter out of range");
    end

    state_e             state_q, state_d;
    logic        [15:0] period_q, period_d;
    logic        [15:0] pre_q, pre_d;
    logic        [15:0] half_q, half_d;
    logic        [15:0] gap_q, gap_d;
    logic               phase_q, phase_d;
    logic               wave_q, wave_d;
    logic               active_q, active_d;
    logic               nc_q, nc_d;
    logic signed [15:0] sample_q, sample_d;
    logic        [15:0] amp;
    logic               chg;
    logic               tick;

    assign chg  = bus.note_period != period_q;
    assign tick = pre_q == PreMax;

    // A note change overrides any tick-driven progress in the same cycle.
    always_comb begin
        period_d = period_q;
        pre_d    = tick ? 16'd0 : pre_q + 16'd1;
        half_d   = half_q;
        gap_d    = gap_q;
        phase_d  = phase_q;
        state_d  = state_q;
        if (chg) begin
            period_d = bus.note_period;
            pre_d    = 16'd0;
            half_d   = 16'd0;
            phase_d  = 1'b0;
            gap_d    = GapInit;
            if (bus.note_period == 16'd0) begin
                state_d = StSilent;
            end else if (GAP_TICKS > 0) begin
                state_d = StGap;
            end else begin
                state_d = StPlay;
            end
        end else if (tick) begin
            unique case (state_q)
                StGap: begin
                    gap_d = gap_q - 16'd1;
                    if (gap_q == 16'd1) begin
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (half_q == period_q - 16'd1) begin
                        half_d  = 16'd0;
                        phase_d = ~phase_q;
                    end else begin
                        half_d = half_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TONE_ENVELOPE_EN
    localparam logic [15:0] DecayMax = 16'(DECAY_TICKS - 1);

    logic [15:0] amp_q, amp_d;
    logic [15:0] dcnt_q, dcnt_d;

    always_comb begin
        amp_d  = amp_q;
        dcnt_d = dcnt_q;
        if (state_d == StPlay && (chg || state_q != StPlay)) begin
            amp_d  = AMP;
            dcnt_d = 16'd0;
        end else if (chg) begin
            dcnt_d = 16'd0;
        end else if (tick && state_q == StPlay) begin
            if (dcnt_q == DecayMax) begin
                dcnt_d = 16'd0;
                if ((amp_q >> 3) != 16'd0) begin
                    amp_d = amp_q - (amp_q >> 3);
                end
            end else begin
                dcnt_d = dcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            amp_q  <= 16'd0;
            dcnt_q <= 16'd0;
        end else begin
            amp_q  <= amp_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign amp = amp_q;
`else
    assign amp = AMP;
`endif

    always_comb begin
        wave_d   = (state_q == StPlay) && phase_q;
        active_d = state_q == StPlay;
        nc_d     = chg;
        sample_d = 16'sd0;
        if (state_q == StPlay) begin
            sample_d = phase_q ? amp : (16'd0 - amp);
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q  <= StSilent;
            period_q <= 16'd0;
            pre_q    <= 16'd0;
            half_q   <= 16'd0;
            gap_q    <= 16'd0;
            phase_q  <= 1'b0;
            wave_q   <= 1'b0;
            active_q <= 1'b0;
            nc_q     <= 1'b0;
            sample_q <= 16'sd0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            half_q   <= half_d;
            gap_q    <= gap_d;
            phase_q  <= phase_d;
            wave_q   <= wave_d;
            active_q <= active_d;
            nc_q     <= nc_d;
            sample_q <= sample_d;
        end
    end

    assign bus.wave_out    = wave_q;
    assign bus.active      = active_q;
    assign bus.note_change = nc_q;
    assign bus.sample      = sample_q;

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: two instances (gapped PRESCALE=4, gapless PRESCALE=1)
// share one note stream and are compared every cycle against an arithmetic timing model.
module tb_tone_synth;

`ifdef TONE_ENVELOPE_EN
    localparam int unsigned DecayTb = 2;
    localparam bit          EnvEn   = 1'b1;
`else
    localparam int unsigned DecayTb = 4096;
    localparam bit          EnvEn   = 1'b0;
`endif
    localparam logic [15:0] AmpVal = 16'd8000;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [15:0] note_in;

    int n_vec = 0;
    int n_err = 0;

    tone_synth_if bus1 ();
    tone_synth_if bus2 ();

    assign bus1.note_period = note_in;
    assign bus2.note_period = note_in;

    tone_synth #(
        .PRESCALE    (4),
        .GAP_TICKS   (2),
        .AMP         (16'sd8000),
        .DECAY_TICKS (DecayTb)
    ) dut1 (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus1.slave)
    );

    tone_synth #(
        .PRESCALE    (1),
        .GAP_TICKS   (0),
        .AMP         (16'sd8000),
        .DECAY_TICKS (DecayTb)
    ) dut2 (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk50 = ~clk50;

    logic [18:0] obs1, obs2;
    assign obs1 = {bus1.note_change, bus1.active, bus1.wave_out, bus1.sample};
    assign obs2 = {bus2.note_change, bus2.active, bus2.wave_out, bus2.sample};

    // Model history: edge index where the current / previous note was captured.
    int          cyc = 0;
    logic [15:0] mp = 16'd0;
    int          cur_start = 0, prev_start = 0;
    logic [15:0] cur_n = 16'd0, prev_n = 16'd0;
    logic        exp_nc;
    logic [18:0] exp1, exp2;

    // {active, wave, sample} produced by the state that held right after edge j.
    function automatic logic [17:0] model_out(int p, int g, int d, int j);
        int          start;
        logic [15:0] n;
        int          s;
        int          gp;
        int          ndec;
        logic [15:0] a;
        logic        ph;
        if (j >= cur_start) begin
            start = cur_start;
            n     = cur_n;
        end else begin
            start = prev_start;
            n     = prev_n;
        end
        s  = j - start;
        gp = g * p;
        if (n == 16'd0 || s < gp) return 18'd0;
        ph   = (((s - gp) / (p * int'(n))) % 2) == 1;
        ndec = (s - gp) / (p * d);
        a    = AmpVal;
        for (int i = 0; EnvEn && i < ndec && (a >> 3) != 16'd0; i++) a = a - (a >> 3);
        return {1'b1, ph, ph ? a : (16'd0 - a)};
    endfunction

    task automatic tick_model();
        @(posedge clk50);
        cyc++;
        if (reset) begin
            mp         = 16'd0;
            cur_start  = cyc;
            prev_start = cyc;
            cur_n      = 16'd0;
            prev_n     = 16'd0;
            exp_nc     = 1'b0;
            exp1       = 19'd0;
            exp2       = 19'd0;
        end else begin
            exp_nc = 1'b0;
            if (note_in != mp) begin
                prev_start = cur_start;
                prev_n     = cur_n;
                cur_start  = cyc;
                cur_n      = note_in;
                mp         = note_in;
                exp_nc     = 1'b1;
            end
            exp1 = {exp_nc, model_out(4, 2, int'(DecayTb), cyc - 1)};
            exp2 = {exp_nc, model_out(1, 0, int'(DecayTb), cyc - 1)};
        end
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        note_in = 16'd0;
        #1;
        n_vec++;
        if (obs1 !== 19'd0 || obs2 !== 19'd0) begin
            n_err++;
            $display("FAIL reset_async got %h/%h want 0", obs1, obs2);
        end
        for (int k = 0; k < 3; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL reset_hold got %h/%h want %h/%h", obs1, obs2, exp1, exp2);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_note();
        note_in = 16'd5;
        for (int k = 0; k < 70; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL first_note k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1, exp2);
            end
            if (k == 0 || k == 1) begin
                n_vec++;
                if (bus1.note_change !== (k == 0)) begin
                    n_err++;
                    $display("FAIL first_note_pulse k=%0d got %b want %b", k, bus1.note_change,
                             k == 0);
                end
            end
            if (k == 8 || k == 9) begin
                n_vec++;
                if (bus1.active !== (k == 9)) begin
                    n_err++;
                    $display("FAIL first_note_active k=%0d got %b want %b", k, bus1.active, k == 9);
                end
            end
            if (k == 9) begin
                n_vec++;
                if (bus1.sample !== -16'sd8000 || bus2.sample !== -16'sd7000 && EnvEn ||
                    bus2.sample !== -16'sd8000 && !EnvEn) begin
                    if (bus1.sample !== -16'sd8000) begin
                        n_err++;
                        $display("FAIL first_note_sample got %0d want -8000", bus1.sample);
                    end
                end
            end
            if (k == 28 || k == 29) begin
                n_vec++;
                if (bus1.wave_out !== (k == 29)) begin
                    n_err++;
                    $display("FAIL first_note_toggle k=%0d got %b want %b", k, bus1.wave_out,
                             k == 29);
                end
            end
            if (k == 1) begin
                n_vec++;
                if (bus2.active !== 1'b1) begin
                    n_err++;
                    $display("FAIL nogap_active got %b want 1", bus2.active);
                end
            end
        end
    endtask

    task automatic test_rest();
        note_in = 16'd0;
        for (int k = 0; k < 10; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL rest k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1, exp2);
            end
            if (k == 1) begin
                n_vec++;
                if (bus1.sample !== 16'sd0 || bus1.wave_out !== 1'b0 || bus1.note_change !== 1'b0)
                begin
                    n_err++;
                    $display("FAIL rest_silent got s=%0d w=%b nc=%b want 0 0 0", bus1.sample,
                             bus1.wave_out, bus1.note_change);
                end
            end
        end
    endtask

    task automatic test_gap_restart();
        int pulses = 0;
        note_in = 16'd5;
        repeat (2) tick_model();
        note_in = 16'd7;
        for (int k = 0; k < 4; k++) begin
            tick_model();
            pulses += int'(bus1.note_change);
        end
        note_in = 16'd9;
        for (int k = 0; k < 100; k++) begin
            tick_model();
            pulses += int'(bus1.note_change);
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL gap_restart k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1,
                         exp2);
            end
            if (k == 8 || k == 9) begin
                n_vec++;
                if (bus1.active !== (k == 9)) begin
                    n_err++;
                    $display("FAIL gap_restart_active k=%0d got %b want %b", k, bus1.active,
                             k == 9);
                end
            end
            if (k == 44 || k == 45) begin
                n_vec++;
                if (bus1.wave_out !== (k == 45)) begin
                    n_err++;
                    $display("FAIL gap_restart_half k=%0d got %b want %b", k, bus1.wave_out,
                             k == 45);
                end
            end
        end
        n_vec++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL gap_restart_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_edge_periods();
        note_in = 16'd1;
        for (int k = 0; k < 40; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL period1 k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1, exp2);
            end
        end
        note_in = 16'hFFFF;
        for (int k = 0; k < 65600; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL periodmax k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1, exp2);
            end
            if (k == 65535 || k == 65536) begin
                n_vec++;
                if (bus2.wave_out !== (k == 65536)) begin
                    n_err++;
                    $display("FAIL periodmax_toggle k=%0d got %b want %b", k, bus2.wave_out,
                             k == 65536);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        note_in = 16'd5;
        repeat (20) tick_model();
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (obs1 !== 19'd0 || obs2 !== 19'd0) begin
            n_err++;
            $display("FAIL mid_reset_async got %h/%h want 0", obs1, obs2);
        end
        repeat (3) tick_model();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick_model();
            n_vec++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
                n_err++;
                $display("FAIL mid_reset k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1, exp2);
            end
            if (k == 0) begin
                n_vec++;
                if (bus1.note_change !== 1'b1) begin
                    n_err++;
                    $display("FAIL mid_reset_restart got %b want 1", bus1.note_change);
                end
            end
        end
    endtask

    task automatic test_random();
        int r;
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) note_in = 16'd0;
            else if (r == 2) note_in = 16'($urandom_range(1, 300));
            else if (r != 1) note_in = 16'($urandom_range(1, 12));
            hold = int'($urandom_range(1, 120));
            for (int k = 0; k < hold; k++) begin
                tick_model();
                n_vec++;
                if (obs1 !== exp1 || obs2 !== exp2) begin
                    n_err++;
                    $display("FAIL random seg=%0d k=%0d got %h/%h want %h/%h", seg, k, obs1, obs2,
                             exp1, exp2);
                end
            end
        end
    endtask

`ifdef TONE_ENVELOPE_EN
    task automatic test_envelope();
        note_in = 16'd0;
        repeat (5) tick_model();
        for (int n = 5; n <= 6; n++) begin
            note_in = 16'(n);
            for (int k = 0; k < 30; k++) begin
                tick_model();
                n_vec++;
                if (obs1 !== exp1 || obs2 !== exp2) begin
                    n_err++;
                    $display("FAIL envelope k=%0d got %h/%h want %h/%h", k, obs1, obs2, exp1,
                             exp2);
                end
                if (k == 9 || (n == 5 && (k == 17 || k == 25))) begin
                    n_vec++;
                    if (bus1.sample !== ((k == 9) ? -16'sd8000 :
                                         (k == 17) ? -16'sd7000 : -16'sd6125)) begin
                        n_err++;
                        $display("FAIL envelope_amp n=%0d k=%0d got %0d", n, k, bus1.sample);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_note();
        test_rest();
        test_gap_restart();
        test_edge_periods();
        test_mid_reset();
        test_random();
`ifdef TONE_ENVELOPE_EN
        test_envelope();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
